// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer-width helper for sync_fifo
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write, registered read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // Read sees the pre-write contents, so a read+write on the same slot returns the old word
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and registered read data.
// Defining FIFO_ERR_EN adds overflow/underflow pulse outputs.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    localparam int PW = ptr_width(DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
    // A concurrent read frees a slot, so a write on full is still accepted
    assign wr_en = we && (!full || re);
    assign rd_en = re && !empty;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
`ifdef FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= we && full;
            underflow <= re && empty && !we;
        end
`endif
    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr[PW-2:0]),
        .wdata (data_in),
        .re    (rd_en),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (data_out)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized scoreboard bench for sync_fifo against a queue model
module tb_sync_fifo;
    logic clk = 1'b0, rst = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic full, empty;
`ifdef FIFO_ERR_EN
    logic overflow, underflow;
`endif
    int total = 0, bad = 0;
    typedef struct {
        logic [7:0] d;
        bit         e;
        bit         f;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;
    logic [7:0] mq[$];
    logic [7:0] last = '0;

    sync_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .re       (re),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef FIFO_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    // Model: occupancy rules applied to a plain queue, one cycle per call
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit wacc, racc;
        @(negedge clk);
        we = w;
        re = r;
        data_in = d;
        wacc = w && (mq.size() < 16 || r);
        racc = r && mq.size() > 0;
        if (racc) last = mq.pop_front();
        if (wacc) mq.push_back(d);
        exp_q.push_back('{d: last, e: mq.size() == 0, f: mq.size() == 16});
    endtask

    task automatic do_reset();
        @(negedge clk);
        we = 0;
        re = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_dout", data_out, 8'h00);
        check("rst_empty", {7'd0, empty}, 8'd1);
        check("rst_full", {7'd0, full}, 8'd0);
        mq.delete();
        last = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("dout", data_out, cur.d);
            check("empty", {7'd0, empty}, {7'd0, cur.e});
            check("full", {7'd0, full}, {7'd0, cur.f});
        end
    end

    initial begin
        #3 do_reset();
        for (int i = 1; i <= 16; i++) step(1, 0, 8'(i));
        step(1, 0, 8'hFF);
        for (int i = 0; i < 17; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
        step(1, 1, 8'hA5);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h30 + i));
        step(1, 1, 8'h77);
        for (int i = 0; i < 17; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
        step(0, 0, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
        for (int p = 0; p < 8; p++) begin
            int pw = (p % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 60; i++)
                step(($urandom % 100) < pw, ($urandom % 100) < 100 - pw, 8'($urandom));
        end
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        @(negedge clk);
        check("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
